// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Holds the FSM state encoding, default widths and requester IDs.
package mem_arbiter_pkg;
  localparam int ADDR_W_D = 15;
  localparam int DATA_W_D = 16;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD1,
    RD2,
    DONE
  } state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle of the memory arbiter.
// master = requesters, slave = arbiter.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D
) ();
  logic              a_req;
  logic              a_wr;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic              b_req;
  logic              b_wr;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output a_req, a_wr, a_addr, a_wdata,
    output b_req, b_wr, b_addr, b_wdata,
    input  a_ack, b_ack, rdata, busy
  );

  modport slave (
    input  a_req, a_wr, a_addr, a_wdata,
    input  b_req, b_wr, b_addr, b_wdata,
    output a_ack, b_ack, rdata, busy
  );
endinterface

// File: rtl/mem_rr_arb.sv
// Two-way round-robin grant with its own last-grant pointer.
// Pointer resets to "B last" so A wins the first tie.
module mem_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);
  logic last_b;

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): grant = last_b ? 2'b01 : 2'b10;
      (req == 2'b01): grant = 2'b01;
      (req == 2'b10): grant = 2'b10;
      default:        grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      last_b <= 1'b1;
    else if (en && |req)
      last_b <= grant[1];
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of two requesters onto a synchronous
// 32Kx16 memory with a shared tri-state data bus.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_oe,
  output logic              mem_we,
  inout  wire  [DATA_W-1:0] mem_data
);
  state_t            state;
  state_t            state_n;
  logic [1:0]        req;
  logic [1:0]        grant;
  logic              idle;
  logic              sel_wr;
  logic              cmd_wr;
  logic              cmd_id;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] rdata_q;

  assign req  = {bus.b_req, bus.a_req};
  assign idle = (state == IDLE);

  mem_rr_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .en    (idle),
    .grant (grant)
  );

  assign sel_wr = grant[1] ? bus.b_wr : bus.a_wr;

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (|req) state_n = sel_wr ? WR : RD1;
      WR:      state_n = DONE;
      RD1:     state_n = RD2;
      RD2:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Command is captured only at the grant, so later input
  // changes cannot disturb a transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_wr    <= 1'b0;
      cmd_id    <= REQ_A;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (idle && |req) begin
      cmd_wr    <= sel_wr;
      cmd_id    <= grant[1] ? REQ_B : REQ_A;
      cmd_addr  <= grant[1] ? bus.b_addr : bus.a_addr;
      cmd_wdata <= grant[1] ? bus.b_wdata : bus.a_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      rdata_q <= '0;
    else if (state == RD2)
      rdata_q <= mem_data;
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_oe   = 1'b0;
    mem_addr = '0;
    unique case (1'b1)
      (state == WR): begin
        mem_we   = 1'b1;
        mem_addr = cmd_addr;
      end
      (state == RD1), (state == RD2): begin
        mem_oe   = 1'b1;
        mem_addr = cmd_addr;
      end
      default: ;
    endcase
  end

  assign mem_data  = mem_we ? cmd_wdata : 'z;
  assign bus.a_ack = (state == DONE) && (cmd_id == REQ_A);
  assign bus.b_ack = (state == DONE) && (cmd_id == REQ_B);
  assign bus.rdata = rdata_q;
  assign bus.busy  = !idle;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 32Kx16 memory model
// and an ack-ordered scoreboard.
module tb_mem_arbiter;
  typedef struct {
    bit          id;
    bit          rd;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] mem_addr;
  logic        mem_oe;
  logic        mem_we;
  wire  [15:0] mem_data;

  logic [15:0] mem [0:32767];
  logic [15:0] q = 16'h0000;
  logic        bd_we = 1'b0;
  logic [14:0] bd_addr = '0;
  logic [15:0] bd_data = '0;

  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;
  bit   no_we = 1'b0;
  exp_t sbq[$];

  mem_arbiter_if #(.ADDR_W(15), .DATA_W(16)) bus ();

  mem_arbiter #(.ADDR_W(15), .DATA_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_oe   (mem_oe),
    .mem_we   (mem_we),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr] <= mem_data;
    if (mem_oe) q <= mem[mem_addr];
  end

  assign mem_data = mem_oe ? q : 'z;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("bus_we_oe", {31'd0, mem_we && mem_oe}, 32'd0);
      if (mem_oe)
        chk("bus_x", {31'd0, $isunknown(mem_data)}, 32'd0);
      if (no_we)
        chk("rd_no_drive", {31'd0, mem_we}, 32'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (chk_en && (bus.a_ack || bus.b_ack)) begin
      chk("ack_both", {31'd0, bus.a_ack && bus.b_ack}, 32'd0);
      if (sbq.size() == 0) begin
        chk("ack_unexpected", {31'd0, bus.b_ack}, 32'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        chk("ack_id", {31'd0, bus.b_ack}, {31'd0, e.id});
        if (e.rd) chk("rdata", {16'd0, bus.rdata}, {16'd0, e.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ack(input string tag, input bit id,
                          input int exp_lat);
    int lat;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(id ? bus.b_ack : bus.a_ack) && lat < 20);
    chk(tag, lat, exp_lat);
  endtask

  task automatic push(input bit id, input bit rd,
                      input logic [15:0] d);
    exp_t e;
    e.id = id;
    e.rd = rd;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic set_a(input bit r, input bit w,
                       input logic [14:0] ad, input logic [15:0] d);
    bus.a_req = r; bus.a_wr = w; bus.a_addr = ad; bus.a_wdata = d;
  endtask

  task automatic set_b(input bit r, input bit w,
                       input logic [14:0] ad, input logic [15:0] d);
    bus.b_req = r; bus.b_wr = w; bus.b_addr = ad; bus.b_wdata = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_rdata", {16'd0, bus.rdata}, 32'd0);
    chk("rst_ack", {30'd0, bus.a_ack, bus.b_ack}, 32'd0);
    chk("rst_ctl", {30'd0, mem_we, mem_oe}, 32'd0);
    chk("rst_addr", {17'd0, mem_addr}, 32'd0);
  endtask

  initial begin
    set_a(0, 0, '0, '0);
    set_b(0, 0, '0, '0);
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;

    // single requester write then read, and rdata kept over a write
    set_a(1, 1, 15'h0010, 16'hBEEF);
    push(0, 0, '0);
    wait_ack("s1_wr_lat", 0, 2);
    set_a(1, 0, 15'h0010, 16'h0000);
    push(0, 1, 16'hBEEF);
    tick();
    wait_ack("s1_rd_lat", 0, 3);
    set_a(1, 1, 15'h0011, 16'h1234);
    push(0, 0, '0);
    tick();
    wait_ack("s1_wr2_lat", 0, 2);
    set_a(0, 0, '0, '0);
    chk("s1_rdata_hold", {16'd0, bus.rdata}, 32'h0000_BEEF);

    // simultaneous held requests alternate A,B,A,B
    tick();
    do_reset();
    set_a(1, 1, 15'h0001, 16'h1111);
    set_b(1, 1, 15'h0002, 16'h2222);
    push(0, 0, '0);
    push(1, 0, '0);
    push(0, 1, 16'h1111);
    push(1, 1, 16'h2222);
    wait_ack("s2_a1", 0, 2);
    set_a(1, 0, 15'h0001, 16'h0000);
    wait_ack("s2_b1", 1, 3);
    set_b(1, 0, 15'h0002, 16'h0000);
    wait_ack("s2_a2", 0, 4);
    set_a(0, 0, '0, '0);
    wait_ack("s2_b2", 1, 4);
    set_b(0, 0, '0, '0);

    // B back-to-back reads of the top address
    tick();
    do_reset();
    bd_we = 1'b1; bd_addr = 15'h7FFF; bd_data = 16'hA5A5;
    tick();
    bd_we = 1'b0;
    no_we = 1'b1;
    set_b(1, 0, 15'h7FFF, 16'h0000);
    for (int i = 0; i < 3; i++) push(1, 1, 16'hA5A5);
    wait_ack("s3_rd1", 1, 3);
    wait_ack("s3_rd2", 1, 4);
    wait_ack("s3_rd3", 1, 4);
    set_b(0, 0, '0, '0);
    tick();
    no_we = 1'b0;
    chk("s3_rdata", {16'd0, bus.rdata}, 32'h0000_A5A5);

    // reset during RD2 abandons the read and re-arms the pointer
    set_a(1, 0, 15'h0010, 16'h0000);
    tick();
    tick();
    chk("s4_rd2_oe", {31'd0, mem_oe}, 32'd1);
    chk("s4_rd2_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_a(0, 0, '0, '0);
    chk("s4_busy", {31'd0, bus.busy}, 32'd0);
    chk("s4_ack", {30'd0, bus.a_ack, bus.b_ack}, 32'd0);
    chk("s4_rdata", {16'd0, bus.rdata}, 32'd0);
    chk("s4_oe", {31'd0, mem_oe}, 32'd0);
    tick();
    tick();
    set_a(1, 1, 15'h0020, 16'h5555);
    set_b(1, 1, 15'h0021, 16'h6666);
    push(0, 0, '0);
    push(1, 0, '0);
    wait_ack("s4_tie_a", 0, 2);
    set_a(0, 0, '0, '0);
    wait_ack("s4_tie_b", 1, 3);
    set_b(0, 0, '0, '0);

    // B waits behind A's read; A traffic must not touch B's command
    tick();
    set_a(1, 0, 15'h0001, 16'h0000);
    push(0, 1, 16'h1111);
    tick();
    set_b(1, 1, 15'h0002, 16'h3333);
    push(1, 0, '0);
    wait_ack("s5_a_rd", 0, 2);
    set_a(0, 1, 15'h0002, 16'hDEAD);
    wait_ack("s5_b_wr", 1, 3);
    set_b(1, 0, 15'h0002, 16'h0000);
    push(1, 1, 16'h3333);
    tick();
    wait_ack("s5_b_rd", 1, 3);
    set_b(0, 0, '0, '0);
    set_a(1, 0, 15'h0001, 16'h0000);
    push(0, 1, 16'h1111);
    tick();
    wait_ack("s5_a_rd2", 0, 3);
    set_a(0, 0, '0, '0);

    tick();
    tick();
    chk("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 15, memory word-address width.
REQ-002 Parameter: DATA_W, 16, memory data width.
REQ-003 Port: clk  input  1  sole clock; all state updates on posedge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: a_req  input  1  requester A transaction request; held high until a_ack.
REQ-006 Port: a_wr  input  1  requester A direction, 1 = write, 0 = read; stable while a_req high.
REQ-007 Port: a_addr  input  ADDR_W  requester A word address; stable while a_req high.
REQ-008 Port: a_wdata  input  DATA_W  requester A write data; stable while a_req high.
REQ-009 Port: a_ack  output  1  one-cycle completion pulse to requester A.
REQ-010 Ports: b_req, b_wr, b_addr, b_wdata, b_ack: same as the A ports, for requester B.
REQ-011 Port: rdata  output  DATA_W  read data; valid in the cycle a_ack or b_ack pulses for a read.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: mem_addr  output  ADDR_W  address to the synchronous 32Kx16 memory.
REQ-014 Port: mem_oe  output  1  memory output enable.
REQ-015 Port: mem_we  output  1  memory write enable; memory writes on the posedge where mem_we=1.
REQ-016 Port: mem_data  inout  DATA_W  shared memory bus; the arbiter drives it only while mem_we=1, otherwise high-Z.

Function
REQ-017 FSM states: IDLE, WR, RD1, RD2, DONE; outputs to memory decode from the registered state and the latched command only.
REQ-018 IDLE: if any req is high, grant one, latch its wr/addr/wdata and requester ID, then go to WR (wr=1) or RD1 (wr=0); otherwise stay.
REQ-019 Arbitration: round-robin. A single requester wins. With both high, the requester not granted last wins. After reset, A wins the first tie.
REQ-020 WR: mem_we=1, mem_oe=0, mem_addr=latched addr, mem_data=latched wdata; next state DONE.
REQ-021 RD1: mem_oe=1, mem_we=0, mem_addr=latched addr; memory captures the word at this edge; next state RD2.
REQ-022 RD2: mem_oe=1, mem_we=0, address held; rdata register samples mem_data at the end of the cycle; next state DONE.
REQ-023 DONE: the granted requester's ack=1 for exactly this cycle. Memory controls are inactive and no arbitration occurs. Next state IDLE.
REQ-024 Latency from req sampled in IDLE to ack: write 2 cycles, read 3 cycles. Minimum cycles per transaction: write 3, read 4.
REQ-025 rdata holds its last read value until the next read completes; writes leave it unchanged.
REQ-026 A requester that keeps req high after its ack is treated as issuing a new request at the next IDLE.
REQ-027 Requests that arrive while busy=1 wait; a request is never dropped, and its latched command is unaffected by later input changes.
REQ-028 mem_we and mem_oe are never both 1, and mem_data is never driven while mem_oe=1.
REQ-029 A read or write to address 0x7FFF behaves identically to any other address; there is no address wrap or offset.

Reset
REQ-030 reset=1 at a posedge forces IDLE, a_ack=b_ack=0, rdata=0, busy=0, and round-robin pointer = "B last".
REQ-031 While the state is IDLE, mem_we=0, mem_oe=0, mem_addr=0 and mem_data is high-Z.
REQ-032 Reset mid-transaction abandons it with no ack.
REQ-033 A write whose WR cycle coincides with reset still lands in memory, because mem_we is high at that edge; it is not acked.

Structure
REQ-034 Package mem_arbiter_pkg holds the FSM state enum, ADDR_W/DATA_W defaults and the requester-ID constants (REQ_A=0, REQ_B=1).
REQ-035 The two-way round-robin grant logic, including its pointer register, is a sub-module mem_rr_arb (inputs req[1:0]; outputs grant[1:0]; update-enable from IDLE).
REQ-036 The bench instantiates mem_arbiter together with the 32Kx16 memory model on a shared mem_data net.

Verification
REQ-037 A writes 0xBEEF to 0x0010, then A reads 0x0010 -> a_ack 2 cycles after the write request, then 3 cycles after the read request, with rdata=0xBEEF.
REQ-038 A and B request in the same cycle (A write 0x1111@0x0001, B write 0x2222@0x0002), held high -> order A,B,A,B; reads show 0x1111/0x2222.
REQ-039 B alone, back-to-back reads of 0x7FFF (preloaded 0xA5A5) -> b_ack every 4 cycles, rdata=0xA5A5; mem_data never driven by the arbiter.
REQ-040 Reset asserted during RD2 -> next cycle IDLE, no ack, rdata=0, mem_oe=0; the next tie grants A.
REQ-041 Bus checker over all scenarios -> never mem_we&&mem_oe; no X on mem_data while mem_oe=1 in RD2.
REQ-042 B requests while A's read is in RD1 -> B is granted at the IDLE following A's DONE, and B's latched command is unaffected by A traffic.
